// File: rtl/mmio_uart_key_bridge_if.sv
// CPU-side memory-mapped bus seen by the UART/keyboard bridge.
// Enables are level signals; the bridge acts on their rising edges.
interface mmio_uart_key_bridge_if;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;

    modport master (
        output bus_address,
        output bus_write_data,
        output bus_write_enable,
        output bus_read_enable,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_write_data,
        input  bus_write_enable,
        input  bus_read_enable,
        output bus_read_data
    );
endinterface

// File: rtl/mmio_uart_key_bridge.sv
// Memory-mapped bridge: CPU writes feed an 8N1 UART transmitter through a byte FIFO,
// and keyboard scan bytes are buffered for CPU reads with an optional interrupt.
module mmio_uart_key_bridge #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_uart_key_bridge_if.slave bus,
    input  logic [7:0]            key_data,
    input  logic                  key_valid,
    output logic                  uart_tx,
    output logic [3:0]            interrupt_vector
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_ART_DATA   = 32'h8000_0000;
    localparam logic [31:0] ADDR_ART_STATUS = 32'h8000_0008;
    localparam logic [31:0] ADDR_KEY_DATA   = 32'h8000_0010;
    localparam logic [31:0] ADDR_KEY_CTRL   = 32'h8000_0018;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic              we_prev_reg, re_prev_reg;
    logic [63:0]       read_data_reg, read_data_next;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [1:0]        state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg, tx_overflow_reg;
    logic [7:0]        key_buf_reg;
    logic              key_pending_reg, key_overrun_reg, irq_en_reg;
    logic [3:0]        irq_vec_reg;

    logic [31:0] addr;
    logic wr_accept, rd_accept;
    logic art_data_wr, art_status_wr, key_ctrl_wr, key_data_rd;
    logic fifo_full, fifo_empty, push, pop, tx_busy, overrun_set, baud_end;
    logic unused_bus_bits;

    assign addr          = bus.bus_address[31:0];
    assign wr_accept     = bus.bus_write_enable & ~we_prev_reg;
    assign rd_accept     = bus.bus_read_enable & ~re_prev_reg;
    assign art_data_wr   = wr_accept & (addr == ADDR_ART_DATA);
    assign art_status_wr = wr_accept & (addr == ADDR_ART_STATUS);
    assign key_ctrl_wr   = wr_accept & (addr == ADDR_KEY_CTRL);
    assign key_data_rd   = rd_accept & (addr == ADDR_KEY_DATA);
    // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a push.
    assign fifo_full     = (count_reg == CNT_FULL);
    assign fifo_empty    = (count_reg == '0);
    assign push          = art_data_wr & ~fifo_full;
    assign pop           = (state_reg == ST_IDLE) & ~fifo_empty;
    assign tx_busy       = (state_reg != ST_IDLE);
    assign baud_end      = (baud_cnt_reg == BAUD_LAST);
    assign overrun_set   = key_valid & key_pending_reg & ~key_data_rd;
    assign unused_bus_bits = ^{bus.bus_address[63:32], bus.bus_write_data[63:8]};

    assign bus.bus_read_data = read_data_reg;
    assign uart_tx           = tx_reg;
    assign interrupt_vector  = irq_vec_reg;

    always_comb begin
        read_data_next = '0;
        case (addr)
            ADDR_ART_STATUS: read_data_next = {60'd0, tx_overflow_reg, tx_busy, fifo_empty, fifo_full};
            ADDR_KEY_DATA:   read_data_next = {56'd0, key_buf_reg};
            ADDR_KEY_CTRL:   read_data_next = {61'd0, irq_en_reg, key_overrun_reg, key_pending_reg};
            default:         ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_prev_reg   <= 1'b0;
            re_prev_reg   <= 1'b0;
            read_data_reg <= '0;
        end else begin
            we_prev_reg <= bus.bus_write_enable;
            re_prev_reg <= bus.bus_read_enable;
            if (rd_accept)
                read_data_reg <= read_data_next;
        end
    end

    // Storage has no reset; clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.bus_write_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            tx_overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: ;
            endcase
            tx_overflow_reg <= (art_data_wr & fifo_full) | (tx_overflow_reg & ~art_status_wr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg    <= fifo_mem[rd_ptr_reg];
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b0;
                        state_reg    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_buf_reg     <= '0;
            key_pending_reg <= 1'b0;
            key_overrun_reg <= 1'b0;
            irq_en_reg      <= 1'b1;
            irq_vec_reg     <= 4'd0;
        end else begin
            // A fresh strobe outranks a same-cycle read: the byte stays pending.
            if (key_valid) begin
                key_buf_reg     <= key_data;
                key_pending_reg <= 1'b1;
            end else if (key_data_rd) begin
                key_pending_reg <= 1'b0;
            end
            key_overrun_reg <= overrun_set | (key_overrun_reg & ~key_ctrl_wr);
            if (key_ctrl_wr)
                irq_en_reg <= bus.bus_write_data[0];
            irq_vec_reg <= (key_pending_reg & irq_en_reg) ? 4'd1 : 4'd0;
        end
    end
endmodule

// File: doc/mmio_uart_key_bridge.md
MMIO_UART_KEY_BRIDGE -- requirements
Module: mmio_uart_key_bridge

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434: clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries (power of 2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bus_address  input  64  CPU byte address.
REQ-006 SHALL have port bus_write_data  input  64  CPU write data.
REQ-007 SHALL have port bus_write_enable  input  1  level write request from the CPU.
REQ-008 SHALL have port bus_read_enable  input  1  level read request from the CPU.
REQ-009 SHALL have port bus_read_data  output  64  registered read data.
REQ-010 SHALL have port key_data  input  8  scan byte from the keyboard decoder.
REQ-011 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_data.
REQ-012 SHALL have port uart_tx  output  1  serial 8N1 line, idle high.
REQ-013 SHALL have port interrupt_vector  output  4  interrupt code to the CPU.

Function
REQ-014 SHALL decode only bus_address[31:0]: 0x8000_0000 ART_DATA, 0x8000_0008 ART_STATUS, 0x8000_0010 KEY_DATA, 0x8000_0018 KEY_CTRL; every other address is unmapped.
REQ-015 SHALL treat a write as accepted only on the cycle bus_write_enable is 1 and was 0 the previous cycle; a held-high enable causes no further effect.
REQ-016 SHALL treat a read as accepted only on the rising edge of bus_read_enable, detected the same way.
REQ-017 SHALL, on an accepted read, load bus_read_data on the next clock edge (1-cycle latency) and hold it until the next accepted read.
REQ-018 SHALL return 0 for reads of ART_DATA and of unmapped addresses; unmapped writes SHALL have no effect.
REQ-019 SHALL, on an ART_DATA write, push bus_write_data[7:0] into the TX FIFO if count < FIFO_DEPTH before that cycle; otherwise drop the byte and set sticky tx_overflow.
REQ-020 SHALL return ART_STATUS as bit0 full, bit1 empty, bit2 tx_busy (FSM not IDLE), bit3 tx_overflow, other bits 0; any ART_STATUS write SHALL clear tx_overflow.
REQ-021 SHALL run the TX FSM IDLE -> START -> DATA -> STOP -> IDLE, each bit lasting exactly BAUD_DIV cycles.
REQ-022 SHALL, in IDLE with FIFO non-empty, pop one byte and enter START on the same edge; uart_tx SHALL be 1 in IDLE, 0 in START, byte bits LSB first in DATA (8 bits), 1 in STOP.
REQ-023 SHALL allow back-to-back frames: from STOP, go to IDLE, then pop on the following cycle if non-empty (one idle cycle between frames).
REQ-024 SHALL allow a push and a pop in the same cycle with count unchanged; the full check uses the pre-cycle count, so a push to a full FIFO is dropped even if a pop occurs that cycle.
REQ-025 SHALL, on key_valid, latch key_data into key_buf and set key_pending; if key_pending was already 1, overwrite key_buf and set sticky key_overrun.
REQ-026 SHALL, on a KEY_DATA read, return {56'b0, key_buf} and clear key_pending; if key_valid occurs the same cycle, the new byte is latched, key_pending stays 1, and no overrun is set.
REQ-027 SHALL return KEY_CTRL as bit0 key_pending, bit1 key_overrun, bit2 irq_en; a KEY_CTRL write SHALL set irq_en = bus_write_data[0] and clear key_overrun.
REQ-028 SHALL drive interrupt_vector = 4'd1 while key_pending and irq_en are both 1, else 4'd0, registered (1-cycle after key_pending rises).
REQ-029 SHALL process simultaneous bus accesses and key/TX events in the same cycle with no lost side effect, except as stated in REQ-019/REQ-024/REQ-026.

Reset
REQ-030 SHALL, while reset = 0, force bus_read_data = 0, uart_tx = 1, interrupt_vector = 0, FIFO empty, TX FSM IDLE, baud counter 0, tx_overflow = 0, key_buf = 0, key_pending = 0, key_overrun = 0, irq_en = 1, and enable-edge history = 0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame immediately (uart_tx = 1) and discard all FIFO contents.
REQ-032 SHALL, after reset release, treat an enable that is already high as a new rising edge on the first clock.

Verification (BAUD_DIV = 4)
REQ-033 SHALL test: write 0x41 to 0x8000_0000 -> uart_tx low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; ART_STATUS reads 0x2 afterwards.
REQ-034 SHALL test: bus_write_enable held high 20 cycles at ART_DATA with 0x55 -> exactly one frame is sent.
REQ-035 SHALL test: 10 writes 0x30..0x39 while TX is stalled in frame 1 -> bytes through 0x38 are queued, 0x39 is dropped, ART_STATUS bit3 = 1, and an ART_STATUS write clears it.
REQ-036 SHALL test: key_valid with 0x1C -> interrupt_vector = 1 one cycle later; KEY_DATA read returns 0x1C and interrupt_vector = 0 within 2 cycles.
REQ-037 SHALL test: two key_valid strobes (0x1C, 0x32) with no read -> KEY_CTRL = 0x7 and KEY_DATA = 0x32; writing 0 to KEY_CTRL gives 0x1 and interrupt_vector = 0.
REQ-038 SHALL test: reset pulsed mid-DATA of frame 2 with 3 bytes queued -> uart_tx = 1 at once, ART_STATUS = 0x2, and no further frames are sent.
